csr_access_unit: RTL

Initiator side of the CSR register file: executes the six Zicsr instructions (CSRRW/S/C and immediate forms) as a read-then-write sequence against the CSR file's synchronous read port and masked write port. Sits in the execute stage between the decoder and the CSR file. It returns the old CSR value for rd and flags illegal accesses to the trap logic.

---
 rtl/core_config_pkg.sv | 53 +++++
 rtl/csr_access_unit.sv | 107 ++++++++++
 2 files changed

// File: rtl/core_config_pkg.sv
// Core-wide configuration: data/CSR address widths and the CSR access unit's
// operation encodings, state type and new-value helpers.
package core_config_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CSR_ADDR_W = 12;

  // Address presented on the CSR ports while nothing has been latched yet.
  localparam logic [CSR_ADDR_W-1:0] CSR_RESET_ADDR = 12'h300;

  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_op_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } csr_acc_state_t;

  // Immediate forms take the zero-extended rs1 index in place of rs1 data.
  function automatic logic [XLEN-1:0] csr_src(input logic [2:0]      funct3,
                                              input logic [4:0]      rs1_idx,
                                              input logic [XLEN-1:0] rs1_data);
    return funct3[2] ? {{(XLEN - 5){1'b0}}, rs1_idx} : rs1_data;
  endfunction

  function automatic logic [XLEN-1:0] csr_modify(input logic [2:0]      funct3,
                                                 input logic [XLEN-1:0] old_val,
                                                 input logic [XLEN-1:0] src);
    logic [XLEN-1:0] res;
    unique case (funct3[1:0])
      2'b01:   res = src;
      2'b10:   res = old_val | src;
      2'b11:   res = old_val & ~src;
      default: res = old_val;
    endcase
    return res;
  endfunction

  // Set/clear forms with rs1 = x0 (or zimm = 0) are pure reads.
  function automatic logic csr_wr_intent(input logic [2:0] funct3,
                                         input logic [4:0] rs1_idx);
    return (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);
  endfunction

endpackage

// File: rtl/csr_access_unit.sv
// Zicsr initiator: runs each CSR instruction as a read cycle followed by a
// (possibly suppressed) masked write, and returns the old value plus an illegal flag.
module csr_access_unit
  import core_config_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [4:0]            req_rs1_idx,
  input  logic [XLEN-1:0]       req_rs1_data,
  input  logic                  flush,
  output logic                  csr_we,
  output logic [CSR_ADDR_W-1:0] csr_wa,
  output logic [XLEN-1:0]       csr_wd,
  output logic [CSR_ADDR_W-1:0] csr_ra,
  input  logic [XLEN-1:0]       csr_rd,
  input  logic                  csr_err,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_data,
  output logic                  rsp_illegal
);

  csr_acc_state_t        state_q, state_d;
  logic [2:0]            funct3_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [4:0]            rs1_idx_q;
  logic [XLEN-1:0]       rs1_data_q;
  logic                  err_q;
  logic [XLEN-1:0]       rsp_data_q;
  logic                  rsp_illegal_q;

  logic                  accept;
  logic [XLEN-1:0]       src;
  logic [XLEN-1:0]       new_val;
  logic                  wr_intent;
  logic                  illegal;

  // A flush in IDLE blocks acceptance even though req_ready is high.
  assign accept    = (state_q == IDLE) && req_valid && !flush;
  assign src       = csr_src(funct3_q, rs1_idx_q, rs1_data_q);
  assign new_val   = csr_modify(funct3_q, csr_rd, src);
  assign wr_intent = csr_wr_intent(funct3_q, rs1_idx_q);
  assign illegal   = err_q || (funct3_q[1:0] == 2'b00) ||
                     (wr_intent && (addr_q[11:10] == 2'b11));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      funct3_q      <= 3'b000;
      addr_q        <= CSR_RESET_ADDR;
      rs1_idx_q     <= 5'd0;
      rs1_data_q    <= '0;
      err_q         <= 1'b0;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            rs1_idx_q  <= req_rs1_idx;
            rs1_data_q <= req_rs1_data;
          end
        end
        READ:  err_q <= csr_err;
        WRITE: begin
          rsp_data_q    <= csr_rd;
          rsp_illegal_q <= illegal;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = flush ? IDLE : WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == IDLE);
    csr_ra      = addr_q;
    csr_wa      = addr_q;
    csr_we      = 1'b0;
    csr_wd      = '0;
    rsp_valid   = (state_q == RESP);
    rsp_data    = rsp_data_q;
    rsp_illegal = rsp_illegal_q;
    if (state_q == WRITE) begin
      csr_we = wr_intent && !illegal && !rst;
      csr_wd = new_val;
    end
  end

endmodule
